// File: rtl/matrix_load_sched_if.sv
// ---------------------------------------------------------------------------
// matrix_load_sched_if
// Bundles the command, word-stream, bank-loader and compute handshakes of
// matrix_load_sched.
//   master : the surrounding system. It drives cmd_valid/cmd_sel, in_data/in_valid
//            and mult_done.
//   slave  : the scheduler. It drives cmd_ready, in_ready, a_/b_opcode,
//            a_/b_data, mult_start, a_/b_loaded and busy.
// ---------------------------------------------------------------------------
interface matrix_load_sched_if #(
    parameter int WORD_W = 32
);
    logic              cmd_valid;
    logic              cmd_sel;
    logic              cmd_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              a_opcode;
    logic              b_opcode;
    logic [WORD_W-1:0] a_data;
    logic [WORD_W-1:0] b_data;
    logic              mult_start;
    logic              mult_done;
    logic              a_loaded;
    logic              b_loaded;
    logic              busy;

    modport master (
        output cmd_valid, cmd_sel, in_data, in_valid, mult_done,
        input  cmd_ready, in_ready, a_opcode, b_opcode, a_data, b_data,
               mult_start, a_loaded, b_loaded, busy
    );

    modport slave (
        input  cmd_valid, cmd_sel, in_data, in_valid, mult_done,
        output cmd_ready, in_ready, a_opcode, b_opcode, a_data, b_data,
               mult_start, a_loaded, b_loaded, busy
    );
endinterface

// File: rtl/matrix_load_sched.sv
// ---------------------------------------------------------------------------
// matrix_load_sched
// Streams WORDS-word matrices into bank A or bank B. Once both banks hold a
// complete matrix, it fires a one-cycle compute start and then waits for the
// compute to complete.
// Ports:
//   clk   : single clock. All logic runs on the rising edge.
//   reset : synchronous, active-high reset.
//   bus   : matrix_load_sched_if.slave. This carries the command handshake,
//           the word stream, the bank strobes and data, compute start/done,
//           the loaded flags and busy.
// ---------------------------------------------------------------------------
module matrix_load_sched #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    matrix_load_sched_if.slave   bus
);
    localparam int CNT_W = $clog2(WORDS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        START,
        WAIT
    } state_e;

    state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       sel_q, sel_d;      // 0 = bank A, 1 = bank B
    logic       a_loaded_q, a_loaded_d;
    logic       b_loaded_q, b_loaded_d;

    logic       word_hs;
    logic       last_word;

    assign word_hs   = (state_q == LOAD) && bus.in_valid;
    assign last_word = (cnt_q == CNT_W'(WORDS - 1));

    // State register
    // NOTE: sequential state is assigned with <= only, so that every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sel_q      <= 1'b0;
            a_loaded_q <= 1'b0;
            b_loaded_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            a_loaded_q <= a_loaded_d;
            b_loaded_q <= b_loaded_d;
        end
    end

    // Next-state logic
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        a_loaded_d = a_loaded_q;
        b_loaded_d = b_loaded_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    sel_d   = bus.cmd_sel;
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (word_hs) begin
                    // With a power-of-two WORDS, the counter wraps to 0 on
                    // the last word by itself.
                    cnt_d = cnt_q + 1'b1;
                    if (last_word) begin
                        if (sel_q) b_loaded_d = 1'b1;
                        else       a_loaded_d = 1'b1;
                        // Reloading a bank that is already loaded leaves its
                        // flag set. A compute starts only when both banks are
                        // complete.
                        state_d = (a_loaded_d && b_loaded_d) ? START : IDLE;
                    end
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (bus.mult_done) begin
                    a_loaded_d = 1'b0;
                    b_loaded_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic. The strobes and data are combinational from in_valid, so
    // each word reaches its bank in the same cycle as its handshake.
    always_comb begin
        bus.cmd_ready  = (state_q == IDLE);
        bus.in_ready   = (state_q == LOAD);
        bus.a_opcode   = word_hs && !sel_q;
        bus.b_opcode   = word_hs &&  sel_q;
        bus.a_data     = (word_hs && !sel_q) ? bus.in_data : '0;
        bus.b_data     = (word_hs &&  sel_q) ? bus.in_data : '0;
        bus.mult_start = (state_q == START);
        bus.busy       = (state_q != IDLE);
        bus.a_loaded   = a_loaded_q;
        bus.b_loaded   = b_loaded_q;
    end
endmodule

// File: doc/matrix_load_sched.md
MATRIX_LOAD_SCHED -- requirements
Module: matrix_load_sched

Interface
REQ-001 Parameter: WORD_W, 32, data word width.
REQ-002 Parameter: WORDS, 4, words per matrix load (power of two, >=2).
REQ-003 Port: clk  in  1  single clock; all logic on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: cmd_valid  in  1  load command offered.
REQ-006 Port: cmd_sel  in  1  target bank: 0 = A, 1 = B.
REQ-007 Port: cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-008 Port: in_data  in  WORD_W  matrix word stream.
REQ-009 Port: in_valid  in  1  in_data valid.
REQ-010 Port: in_ready  out  1  word consumed when in_valid & in_ready.
REQ-011 Port: a_opcode / b_opcode  out  1 each  write strobe to bank A / B loader.
REQ-012 Port: a_data / b_data  out  WORD_W each  word to bank A / B loader.
REQ-013 Port: mult_start  out  1  one-cycle compute-start pulse.
REQ-014 Port: mult_done  in  1  compute-complete pulse.
REQ-015 Port: a_loaded / b_loaded  out  1 each  bank holds a complete matrix.
REQ-016 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-017 States: IDLE, LOAD, START, WAIT; encoding free.
REQ-018 IDLE: cmd_ready=1, in_ready=0; on cmd handshake latch cmd_sel, clear word count, go to LOAD next cycle.
REQ-019 LOAD: cmd_ready=0, in_ready=1; each word handshake drives opcode=1 and data=in_data on the selected bank the same cycle (combinational, zero latency); other bank opcode=0.
REQ-020 LOAD, in_valid=0: both opcodes 0, word count holds; gaps of any length allowed.
REQ-021 Word count increments per handshake, width log2(WORDS); on the WORDS-th word: set the selected bank's loaded flag, count wraps to 0, leave LOAD next cycle.
REQ-022 After the last word: if both loaded flags are then set, go to START, else IDLE.
REQ-023 Command to an already-loaded bank is accepted; it overwrites that bank; flag stays set.
REQ-024 START: lasts exactly one cycle, mult_start=1, then WAIT; mult_start is 0 in all other states.
REQ-025 WAIT: cmd_ready=0, in_ready=0; on mult_done=1 clear both loaded flags, go to IDLE next cycle.
REQ-026 mult_done outside WAIT: ignored.
REQ-027 Strobes: a_opcode/b_opcode never both 1; each strobe is 1 only while in LOAD with in_valid=1.
REQ-028 a_data/b_data: equal in_data whenever the matching opcode=1, otherwise hold 0.
REQ-029 Throughput: a WORDS-word load with no gaps takes 1 (cmd) + WORDS cycles; the next cmd is accepted on the cycle after return to IDLE.

Reset
REQ-030 When reset is 1 at a clock edge: state=IDLE, count=0, a_loaded=b_loaded=0, latched sel=0.
REQ-031 Outputs after reset: cmd_ready=1, in_ready=0, opcodes=0, data=0, mult_start=0, busy=0.
REQ-032 Reset during LOAD or WAIT abandons the operation; no further strobes are issued and the partial load is not flagged.
REQ-033 Reset overrides any simultaneous handshake or mult_done.

Verification
REQ-034 Load A (cmd_sel=0), words 0x11,0x22,0x33,0x44 back-to-back -> a_opcode high for 4 cycles with those words, a_loaded=1, b_opcode always 0, back in IDLE, no mult_start.
REQ-035 After REQ-034, load B with in_valid toggling 1,0,1,0,... -> b_opcode high only on valid cycles (4 total), b_loaded=1, mult_start pulses exactly 1 cycle, busy stays 1.
REQ-036 In WAIT, assert cmd_valid and in_valid for 10 cycles -> cmd_ready=0, in_ready=0, no strobes; mult_done=1 -> both flags 0, IDLE, cmd_ready=1.
REQ-037 Reset after word 2 of a B load -> b_loaded=0, count=0; a fresh 4-word B load then completes normally with the correct words.
REQ-038 Load A twice (0xA0.. then 0xB0..) -> 8 a_opcode strobes, a_loaded=1, no mult_start.
REQ-039 mult_done pulsed in IDLE with a_loaded=1 -> a_loaded remains 1, state unchanged.
